gumnut_rx_port_fifo: RTL and testbench
======================================

// Module: gumnut_rx_port_fifo
// PURPOSE
//  Buffered input peripheral on the Gumnut I/O port bus (cyc/stb/we/ack, 8-bit adr/dat).
//  Accepts bytes from an external valid/ready source into a FIFO.
//  Exposes DATA/STATUS/CTRL registers to the core.
//  Raises int_req to the core's interrupt input when the fill level reaches a threshold.
// PARAMETERS
//  BASE_ADDR  8'h10  port address of DATA; STATUS = BASE_ADDR+1; CTRL = BASE_ADDR+2
//  DEPTH      16     FIFO entries; power of 2, range 2..16
//  THRESH     4      fill level (1..DEPTH) at which an interrupt is requested
// PORTS
//  clk_i        in   1  system clock, all state updates on rising edge
//  rst_i        in   1  reset, asynchronous, active-low
//  port_cyc_i   in   1  bus cycle valid
//  port_stb_i   in   1  strobe; held with cyc/adr/we/dat until ack
//  port_we_i    in   1  1 = write, 0 = read
//  port_ack_o   out  1  single-cycle acknowledge
//  port_adr_i   in   8  port address
//  port_dat_i   in   8  write data from core
//  port_dat_o   out  8  read data, valid while port_ack_o=1
//  int_req_o    out  1  interrupt request to core
//  int_ack_i    in   1  interrupt acknowledge from core
//  src_valid_i  in   1  source byte valid
//  src_data_i   in   8  source byte
//  src_ready_o  out  1  FIFO can accept (= !full)
// BEHAVIOUR
//  Reset (rst_i=0, async): FIFO empty, count=0, overrun=0, int_en=0, armed=1,
//   port_ack_o=0, port_dat_o=8'h00, int_req_o=0, src_ready_o=1.
//  Bus decode: hit = cyc&stb&(adr in BASE_ADDR..BASE_ADDR+2)&!port_ack_o. Other addresses are never acked.
//  Ack timing: on a hit, register port_ack_o=1 for exactly one cycle.
//   - port_dat_o and all side effects commit on the same edge. Latency is 1 cycle.
//   - port_ack_o=1 blocks a new hit, so no back-to-back acks.
//  Reads:
//   - DATA: returns FIFO head and pops it. If empty, returns 8'h00 with no pointer change.
//   - STATUS: returns {overrun,full,empty,count[4:0]} and clears overrun on that edge.
//     A new overrun on the same edge wins.
//   - CTRL: returns {6'b0,1'b0,int_en}.
//  Writes:
//   - CTRL: bit0 -> int_en; bit1=1 flushes the FIFO (pointers and count to 0; overrun unchanged).
//   - DATA and STATUS writes are acked and otherwise ignored.
//  Push: src_valid_i & !full pushes src_data_i.
//   - src_valid_i & full drops the byte and sets overrun (sticky).
//   - Full is evaluated at the start of the cycle; a same-cycle pop does not make room.
//  Simultaneous push and pop: both occur and count is unchanged. Pop reads the old head.
//  Flush with a push on the same edge: flush wins, the byte is dropped, overrun is not set.
//  Pointers: log2(DEPTH) bits, wrap modulo DEPTH. count is 5 bits (0..DEPTH); full = (count==DEPTH).
//  Interrupt:
//   - int_req_o sets when int_en & armed & count>=THRESH.
//   - int_ack_i=1 clears int_req_o and armed. Ack has priority over set on the same edge.
//   - armed returns to 1 when count<THRESH, or when CTRL is written with int_en=0.
//   - int_en=0 forces int_req_o=0 on the next edge.
//   - This gives one request per threshold crossing; the ISR drains below THRESH to re-arm.
//  Reset mid-transfer: all state is cleared asynchronously, and any pending ack is dropped.
//   The core re-issues the cycle after its own reset.
// STRUCTURE
//  Package gumnut_port_pkg:
//   - register offsets REG_DATA=0, REG_STATUS=1, REG_CTRL=2
//   - STATUS bit positions: OVR=7, FULL=6, EMPTY=5, CNT=4:0
//   - CTRL bit positions: INT_EN=0, FLUSH=1
//  Sub-module gumnut_sync_fifo #(WIDTH,DEPTH):
//   - inputs push, pop, flush; outputs head, count, full, empty
//   - storage is a register array; ports use the same clk_i/rst_i.
//  Top level holds bus decode, ack/readback registers, the CTRL register, overrun, and the interrupt FSM.
//   Interrupt FSM states: IDLE(armed), REQ, WAIT_DRAIN(!armed).
// TESTING
//  1. Reset low mid-ack, then release -> port_ack_o=0, int_req_o=0, STATUS read returns 8'h20.
//  2. Push A5,3C; read DATA twice, then a third time -> 1-cycle acks with A5, 3C, then 00;
//     STATUS=8'h20 afterwards.
//  3. Push 17 bytes with DEPTH=16 -> src_ready_o=0 after the 16th byte; STATUS=8'hD0;
//     a second STATUS read returns 8'h50.
//  4. Write CTRL=01, push 4 bytes -> int_req_o rises the edge after the 4th push.
//     Pulse int_ack_i -> int_req_o=0. Push a 5th byte -> no request.
//     Drain to 3 bytes, then push 1 -> int_req_o=1 again.
//  5. Push 1 and read DATA on the same edge at count=3 -> count stays 3, read returns the old head.
//     CTRL=03 written with push active -> count=0, overrun=0.
//  6. Access address BASE_ADDR+3 for 5 cycles -> no ack. Write DATA=FF -> acked, FIFO unchanged.

Source files
------------

// File: rtl/gumnut_port_pkg.sv
// Shared register map, field positions and types for the Gumnut receive port.
// Offsets are relative to the block's BASE_ADDR.
package gumnut_port_pkg;

    localparam int CNT_W = 5;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [7:0] REG_SPAN   = 8'd3;

    localparam int STAT_OVR   = 7;
    localparam int STAT_FULL  = 6;
    localparam int STAT_EMPTY = 5;

    localparam int CTRL_INT_EN = 0;
    localparam int CTRL_FLUSH  = 1;

    typedef struct packed {
        logic             ovr;
        logic             full;
        logic             empty;
        logic [CNT_W-1:0] cnt;
    } status_t;

    typedef enum logic [1:0] {
        INT_IDLE       = 2'd0,
        INT_REQ        = 2'd1,
        INT_WAIT_DRAIN = 2'd2
    } int_state_e;

endpackage

// File: rtl/gumnut_sync_fifo.sv
// Register-array synchronous FIFO with flush; head is the oldest entry.
// Latency: push visible in count/head the edge after; flush wins over push/pop.
// Backpressure: push ignored when full, pop ignored when empty (both sampled pre-edge).
module gumnut_sync_fifo
    import gumnut_port_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly log2(DEPTH) bits so they wrap modulo DEPTH for free.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gumnut_rx_port_fifo.sv
// Gumnut port-bus receive peripheral: byte FIFO behind DATA/STATUS/CTRL with threshold IRQ.
// Latency: one-cycle registered ack, readback and side effects commit on the ack edge.
// Backpressure: src_ready_o = !full; bytes offered while full are dropped and flag overrun.
module gumnut_rx_port_fifo
    import gumnut_port_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h10,
    parameter int         DEPTH     = 16,
    parameter int         THRESH    = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       port_cyc_i,
    input  logic       port_stb_i,
    input  logic       port_we_i,
    output logic       port_ack_o,
    input  logic [7:0] port_adr_i,
    input  logic [7:0] port_dat_i,
    output logic [7:0] port_dat_o,
    output logic       int_req_o,
    input  logic       int_ack_i,
    input  logic       src_valid_i,
    input  logic [7:0] src_data_i,
    output logic       src_ready_o
);

    logic [7:0]       offset;
    logic             hit;
    logic             rd_hit;
    logic             wr_hit;
    logic             data_rd;
    logic             status_rd;
    logic             ctrl_wr;
    logic             flush;
    logic             ovr_set;
    logic             fifo_pop;
    logic [7:0]       fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             above_thresh;
    logic             rearm_wr;
    logic [7:0]       rd_value;
    logic             ovr_q;
    logic             int_en_q;
    status_t          status;
    int_state_e       int_state_q;
    int_state_e       int_state_d;
    logic             unused_dat;

    // Unsigned wrap makes addresses below BASE_ADDR fall outside the window too.
    assign offset  = port_adr_i - BASE_ADDR;
    assign hit     = port_cyc_i & port_stb_i & (offset < REG_SPAN) & ~port_ack_o;
    assign rd_hit  = hit & ~port_we_i;
    assign wr_hit  = hit & port_we_i;

    assign data_rd   = rd_hit & (offset[1:0] == REG_DATA);
    assign status_rd = rd_hit & (offset[1:0] == REG_STATUS);
    assign ctrl_wr   = wr_hit & (offset[1:0] == REG_CTRL);
    assign flush     = ctrl_wr & port_dat_i[CTRL_FLUSH];
    assign rearm_wr  = ctrl_wr & ~port_dat_i[CTRL_INT_EN];
    assign fifo_pop  = data_rd;

    // Overrun uses the pre-edge full flag; a byte lost to a flush is not an overrun.
    assign ovr_set = src_valid_i & fifo_full & ~flush;

    assign src_ready_o  = ~fifo_full;
    assign above_thresh = (fifo_count >= CNT_W'(THRESH));
    assign int_req_o    = (int_state_q == INT_REQ);
    assign unused_dat   = ^port_dat_i[7:2];

    gumnut_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (src_valid_i),
        .pop   (fifo_pop),
        .flush (flush),
        .din   (src_data_i),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        status.ovr   = ovr_q;
        status.full  = fifo_full;
        status.empty = fifo_empty;
        status.cnt   = fifo_count;
    end

    always_comb begin
        rd_value = 8'h00;
        case (offset[1:0])
            REG_DATA:   rd_value = fifo_empty ? 8'h00 : fifo_head;
            REG_STATUS: rd_value = status;
            REG_CTRL:   rd_value = {7'b0, int_en_q};
            default:    rd_value = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            port_ack_o <= 1'b0;
            port_dat_o <= 8'h00;
            int_en_q   <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            port_ack_o <= hit;
            if (rd_hit) begin
                port_dat_o <= rd_value;
            end else if (wr_hit) begin
                port_dat_o <= 8'h00;
            end
            if (ctrl_wr) begin
                int_en_q <= port_dat_i[CTRL_INT_EN];
            end
            ovr_q <= ovr_set | (ovr_q & ~status_rd);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            int_state_q <= INT_IDLE;
        end else begin
            int_state_q <= int_state_d;
        end
    end

    // IDLE is "armed"; WAIT_DRAIN holds off re-requests until the level drops.
    always_comb begin
        int_state_d = int_state_q;
        case (int_state_q)
            INT_IDLE: begin
                if (int_ack_i) begin
                    int_state_d = above_thresh ? INT_WAIT_DRAIN : INT_IDLE;
                end else if (int_en_q && above_thresh) begin
                    int_state_d = INT_REQ;
                end
            end
            INT_REQ: begin
                if (int_ack_i) begin
                    int_state_d = INT_WAIT_DRAIN;
                end else if (!int_en_q) begin
                    int_state_d = INT_IDLE;
                end
            end
            INT_WAIT_DRAIN: begin
                if (!above_thresh || rearm_wr) begin
                    int_state_d = INT_IDLE;
                end
            end
            default: int_state_d = INT_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gumnut_rx_port_fifo.sv
// Directed bench for gumnut_rx_port_fifo: bus register access, FIFO fill/drain, overrun and IRQ.
module tb_gumnut_rx_port_fifo;

    localparam logic [7:0] BASE = 8'h10;
    localparam logic [7:0] A_DATA = BASE;
    localparam logic [7:0] A_STAT = BASE + 8'd1;
    localparam logic [7:0] A_CTRL = BASE + 8'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cyc = 1'b0;
    logic       stb = 1'b0;
    logic       we = 1'b0;
    logic       ack;
    logic [7:0] adr = 8'h00;
    logic [7:0] wdat = 8'h00;
    logic [7:0] rdat;
    logic       int_req;
    logic       int_ack = 1'b0;
    logic       src_valid = 1'b0;
    logic [7:0] src_data = 8'h00;
    logic       src_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gumnut_rx_port_fifo #(
        .BASE_ADDR (BASE),
        .DEPTH     (16),
        .THRESH    (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .port_cyc_i  (cyc),
        .port_stb_i  (stb),
        .port_we_i   (we),
        .port_ack_o  (ack),
        .port_adr_i  (adr),
        .port_dat_i  (wdat),
        .port_dat_o  (rdat),
        .int_req_o   (int_req),
        .int_ack_i   (int_ack),
        .src_valid_i (src_valid),
        .src_data_i  (src_data),
        .src_ready_o (src_ready)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                            output logic [7:0] r, output logic acked);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        acked = 1'b0;
        r = 8'h00;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1;
                r = rdat;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
        logic [7:0] r;
        logic       acked;
        bus_xfer(1'b0, a, 8'h00, r, acked);
        check({tag, "_ack"}, {7'b0, acked}, 8'h01);
        check(tag, r, exp);
        @(posedge clk); #1;
        check({tag, "_ack1cyc"}, {7'b0, ack}, 8'h00);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input string tag);
        logic [7:0] r;
        logic       acked;
        bus_xfer(1'b1, a, d, r, acked);
        check({tag, "_ack"}, {7'b0, acked}, 8'h01);
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        src_valid = 1'b1; src_data = b;
        @(posedge clk); #1;
        src_valid = 1'b0;
    endtask

    task automatic pulse_int_ack();
        @(negedge clk);
        int_ack = 1'b1;
        @(posedge clk); #1;
        int_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_ack", {7'b0, ack}, 8'h00);
        check("rst_dat", rdat, 8'h00);
        check("rst_int", {7'b0, int_req}, 8'h00);
        check("rst_ready", {7'b0, src_ready}, 8'h01);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1. Reset asserted while an ack is on the bus
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STAT;
        @(posedge clk); #1;
        check("t1_ack_before_rst", {7'b0, ack}, 8'h01);
        rst_n = 1'b0;
        #1;
        check("t1_ack_dropped", {7'b0, ack}, 8'h00);
        check("t1_int", {7'b0, int_req}, 8'h00);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd(A_STAT, 8'h20, "t1_status");

        // 2. Two bytes in, three reads out
        push(8'hA5);
        push(8'h3C);
        rd(A_DATA, 8'hA5, "t2_rd0");
        rd(A_DATA, 8'h3C, "t2_rd1");
        rd(A_DATA, 8'h00, "t2_rd_empty");
        rd(A_STAT, 8'h20, "t2_status");

        // 3. Overfill: 17 bytes into 16 entries
        for (int i = 0; i < 17; i++) begin
            push(8'h40 + 8'(i));
            if (i == 14) check("t3_ready_15", {7'b0, src_ready}, 8'h01);
            if (i == 15) check("t3_ready_full", {7'b0, src_ready}, 8'h00);
        end
        rd(A_STAT, 8'hD0, "t3_status_ovr");
        rd(A_STAT, 8'h50, "t3_status_clr");
        wr(A_CTRL, 8'h02, "t3_flush");
        rd(A_STAT, 8'h20, "t3_status_flushed");

        // 4. Threshold interrupt, ack, re-arm after drain
        wr(A_CTRL, 8'h01, "t4_int_en");
        rd(A_CTRL, 8'h01, "t4_ctrl");
        push(8'h10); push(8'h11); push(8'h12); push(8'h13);
        check("t4_int_not_yet", {7'b0, int_req}, 8'h00);
        @(posedge clk); #1;
        check("t4_int_set", {7'b0, int_req}, 8'h01);
        pulse_int_ack();
        check("t4_int_acked", {7'b0, int_req}, 8'h00);
        push(8'h14);
        repeat (2) @(posedge clk);
        #1;
        check("t4_no_rereq", {7'b0, int_req}, 8'h00);
        rd(A_DATA, 8'h10, "t4_drain0");
        rd(A_DATA, 8'h11, "t4_drain1");
        check("t4_still_low", {7'b0, int_req}, 8'h00);
        push(8'h15);
        @(posedge clk); #1;
        check("t4_int_rearmed", {7'b0, int_req}, 8'h01);

        // 5. Same-edge push and pop, then flush racing a push
        pulse_int_ack();
        rd(A_DATA, 8'h12, "t5_rd");
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_DATA;
        src_valid = 1'b1; src_data = 8'h16;
        @(posedge clk); #1;
        src_valid = 1'b0;
        check("t5_pp_ack", {7'b0, ack}, 8'h01);
        check("t5_pp_old_head", rdat, 8'h13);
        cyc = 1'b0; stb = 1'b0;
        rd(A_STAT, 8'h03, "t5_count3");
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_CTRL; wdat = 8'h03;
        src_valid = 1'b1; src_data = 8'h77;
        @(posedge clk); #1;
        src_valid = 1'b0;
        check("t5_flush_ack", {7'b0, ack}, 8'h01);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rd(A_STAT, 8'h20, "t5_flushed");
        rd(A_CTRL, 8'h01, "t5_ctrl");
        check("t5_int_low", {7'b0, int_req}, 8'h00);

        // 6. Out-of-window address, ignored DATA write
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 8'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t6_no_ack", {7'b0, ack}, 8'h00);
        end
        cyc = 1'b0; stb = 1'b0;
        wr(A_DATA, 8'hFF, "t6_wr_data");
        rd(A_STAT, 8'h20, "t6_status");
        rd(A_DATA, 8'h00, "t6_data_empty");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
